sam_mem_arbiter: RTL and testbench
==================================

Name: sam_mem_arbiter

Overview:
- Shares the single 64x8 SAM program/data memory between the CPU fetch/execute port and a console/debug port used for program loading and memory inspection.
- Sequences every access as a fixed-latency command on the En/Rw/Address_Bus memory interface and returns a one-cycle ack with read data.
- Sits between Toplevel's CPU and the memory model. A wrapper merges Data_Out/Data_In onto the tristate Data_Bus.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_DEPTH, 64, number of valid addresses; addresses >= MEM_DEPTH are out of range.
- RD_LAT, 1, cycles from command edge to valid Data_In (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_rw  in  1  1=read, 0=write.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data; valid when cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  (same widths/meaning)  console port.
- pause  in  1  masks new CPU grants.
- En  out  1  memory enable.
- Rw  out  1  memory direction; 1=read, 0=write.
- Address_Bus  out  AW  memory address.
- Data_Out  out  DW  memory write data.
- Data_In  in  DW  memory read data.
- err  out  1  pulses with ack when the access was out of range.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, En=0, Rw=1, Address_Bus=0, Data_Out=0, both acks=0, both rdata=0, err=0, busy=0, last_grant=DBG. An in-flight transaction is dropped and produces no ack.
- All outputs are registered. Rw is held at 1 whenever En=0, so the memory never sees a spurious write.
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE: samples requests. The CPU request is masked when pause=1. If any request is eligible, the winner is chosen round-robin against last_grant, and the winner's rw/addr/wdata are latched. Next state is CMD.
- CMD (1 cycle): En=1, Rw=latched rw, Address_Bus=latched addr, Data_Out=latched wdata (writes only; 0 on reads).
  - In range, read: go to WAIT.
  - In range, write: go to RESP.
  - Out of range: En stays 0 and Rw stays 1; go to RESP with err pending.
- WAIT (RD_LAT cycles): En=0, Rw=1. Data_In is captured at the last WAIT edge. Then go to RESP.
- RESP (1 cycle): the granted port's ack=1. Its rdata = captured data for a read, 0 for a write or an error. err=1 if the access was out of range. last_grant updates to the granted port. Next state is IDLE.
- The non-granted port's ack and rdata stay 0.
- Latency, counting from the IDLE cycle N where the request is sampled:
  - In-range read: ack in cycle N+2+RD_LAT (N+3 by default).
  - Write or error: ack in cycle N+2.
- Throughput: one read per 3+RD_LAT cycles, one write per 3 cycles.
- Requester rules:
  - Hold req and fields until ack; deassert req on the edge that ends the ack cycle. A req still high in the following IDLE is a new request.
  - Dropping req or changing fields after the grant has no effect; the latched transaction completes and acks.
- pause rising mid-CPU-transaction: the transaction completes normally; only new grants are blocked. dbg is unaffected by pause.
- Both ports requesting in IDLE: the port other than last_grant wins. After reset the CPU wins the first tie.
- Address comparison is unsigned against MEM_DEPTH.

Decomposition:
- Package sam_mem_pkg:
  - state enum {IDLE, CMD, WAIT, RESP};
  - owner constants OWNER_CPU=0, OWNER_DBG=1;
  - RW_READ=1, RW_WRITE=0;
  - default AW/DW/MEM_DEPTH.
- Sub-module rr_arbiter2: combinational 2-way round-robin. Inputs: req vector and last_grant. Output: grant one-hot. This is the only natural split; the FSM, latches and WAIT counter stay in sam_mem_arbiter.

Test Plan:
- Hold rst=0 mid-read (state WAIT), release -> En=0, Rw=1, no cpu_ack ever pulses; the next request is serviced normally.
- cpu read 0x13 with mem[0x13]=0x63, req sampled cycle N -> cycle N+1: En=1, Rw=1, Address_Bus=0x13; cycle N+3: cpu_ack=1, cpu_rdata=0x63, err=0.
- dbg write 0xA5 to 0x04 -> cycle N+1: En=1, Rw=0, Data_Out=0xA5; cycle N+2: dbg_ack=1. A following cpu read of 0x04 returns 0xA5.
- cpu and dbg both requesting continuously for 4 transactions -> ack order cpu, dbg, cpu, dbg; no cycle has both acks high.
- pause=1, both requesting -> only dbg serviced, repeatedly. Drop pause -> the next grant is cpu.
- cpu read 0x40 -> En stays 0 throughout; cycle N+2: cpu_ack=1, err=1, cpu_rdata=0x00.

Source files
------------

// File: rtl/sam_mem_pkg.sv
// rtl/sam_mem_pkg.sv - shared types and constants for the SAM memory arbiter
package sam_mem_pkg;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Port identity used for grants and last_grant
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  // Memory direction encoding on Rw
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Default geometry of the SAM program/data memory
  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 8;
  localparam int DEF_MEM_DEPTH = 64;
  localparam int DEF_RD_LAT    = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin arbiter
// Ports:
//   req        in  [1:0]  bit 0 = CPU, bit 1 = debug
//   last_grant in  1      port that was served last (OWNER_CPU / OWNER_DBG)
//   grant      out [1:0]  one-hot winner, zero when nothing requests
module rr_arbiter2
  import sam_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      // Tie: the port that was not served last wins
      grant = (last_grant == OWNER_DBG) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/sam_mem_arbiter.sv
// rtl/sam_mem_arbiter.sv - CPU/debug arbiter and sequencer for the 64x8 SAM memory
// Ports:
//   clk, rst                      clock (rising) and asynchronous active-low reset
//   cpu_req/rw/addr/wdata         CPU access request, rw 1=read 0=write
//   cpu_rdata, cpu_ack            CPU read data and one-cycle completion pulse
//   dbg_req/rw/addr/wdata         console/debug access request
//   dbg_rdata, dbg_ack            console read data and completion pulse
//   pause                         blocks new CPU grants
//   En, Rw, Address_Bus, Data_Out memory command interface (registered)
//   Data_In                       memory read data
//   err                           pulses with ack for an out-of-range access
//   busy                          high whenever the sequencer is not idle
module sam_mem_arbiter
  import sam_mem_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_rw,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  input  logic          pause,
  output logic          En,
  output logic          Rw,
  output logic [AW-1:0] Address_Bus,
  output logic [DW-1:0] Data_Out,
  input  logic [DW-1:0] Data_In,
  output logic          err,
  output logic          busy
);

  localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);
  // One extra bit so MEM_DEPTH == 2**AW still compares correctly
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(MEM_DEPTH);

  state_t        state, state_nx;
  logic          last_grant;
  logic          own;
  logic          lat_rw;
  logic          lat_oor;
  logic [CW-1:0] wait_cnt;

  logic [1:0]    req_vec;
  logic [1:0]    grant;
  logic          take;
  logic          sel_owner;
  logic          sel_rw;
  logic          sel_oor;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          en_nx, rw_nx, err_nx, busy_nx, cack_nx, dack_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] dout_nx, crd_nx, drd_nx, resp_data;

  // ---------------------------------------------------------------
  // Request selection
  // ---------------------------------------------------------------
  assign req_vec = {dbg_req, cpu_req & ~pause};

  rr_arbiter2 u_rr (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign take      = (state == IDLE) && (grant != 2'b00);
  assign sel_owner = grant[1] ? OWNER_DBG : OWNER_CPU;
  assign sel_rw    = grant[1] ? dbg_rw    : cpu_rw;
  assign sel_addr  = grant[1] ? dbg_addr  : cpu_addr;
  assign sel_wdata = grant[1] ? dbg_wdata : cpu_wdata;
  assign sel_oor   = !({1'b0, sel_addr} < DEPTH);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (take) state_nx = CMD;
      CMD:  state_nx = (lat_oor || lat_rw == RW_WRITE) ? RESP : WAIT;
      WAIT: if (wait_cnt == '0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Transaction latch, read-latency counter, round-robin history
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own        <= OWNER_CPU;
      lat_rw     <= RW_READ;
      lat_oor    <= 1'b0;
      wait_cnt   <= '0;
      last_grant <= OWNER_DBG;
    end else begin
      if (take) begin
        own     <= sel_owner;
        lat_rw  <= sel_rw;
        lat_oor <= sel_oor;
      end
      if (state == CMD) begin
        wait_cnt <= CNT_LOAD;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == RESP) begin
        last_grant <= own;
      end
    end
  end

  // ---------------------------------------------------------------
  // FSM: outputs. Every port is registered, so this block computes
  // the value each output takes in the state being entered.
  // ---------------------------------------------------------------
  always_comb begin
    en_nx     = 1'b0;
    rw_nx     = RW_READ;
    addr_nx   = Address_Bus;
    dout_nx   = '0;
    cack_nx   = 1'b0;
    dack_nx   = 1'b0;
    crd_nx    = '0;
    drd_nx    = '0;
    err_nx    = 1'b0;
    busy_nx   = (state_nx != IDLE);
    resp_data = '0;

    // Entering CMD: drive the command; out-of-range keeps En low
    if (take) begin
      addr_nx = sel_addr;
      if (!sel_oor) begin
        en_nx = 1'b1;
        rw_nx = sel_rw;
        if (sel_rw == RW_WRITE) dout_nx = sel_wdata;
      end
    end

    // Entering RESP: only in-range reads arrive from WAIT, and the
    // last WAIT edge is exactly where Data_In is valid
    if (state_nx == RESP) begin
      if (state == WAIT) resp_data = Data_In;
      if (own == OWNER_CPU) begin
        cack_nx = 1'b1;
        crd_nx  = resp_data;
      end else begin
        dack_nx = 1'b1;
        drd_nx  = resp_data;
      end
      err_nx = lat_oor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      En          <= 1'b0;
      Rw          <= RW_READ;
      Address_Bus <= '0;
      Data_Out    <= '0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      En          <= en_nx;
      Rw          <= rw_nx;
      Address_Bus <= addr_nx;
      Data_Out    <= dout_nx;
      cpu_ack     <= cack_nx;
      dbg_ack     <= dack_nx;
      cpu_rdata   <= crd_nx;
      dbg_rdata   <= drd_nx;
      err         <= err_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// tb/tb_sam_mem_arbiter.sv - self-checking bench for sam_mem_arbiter
module tb_sam_mem_arbiter;

  localparam int RD_LAT = 1;
  localparam int NCYC   = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_rw = 1'b1;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       dbg_req = 1'b0, dbg_rw = 1'b1;
  logic [7:0] dbg_addr = '0, dbg_wdata = '0;
  logic [7:0] dbg_rdata;
  logic       dbg_ack;
  logic       pause = 1'b0;
  logic       En, Rw, err, busy;
  logic [7:0] Address_Bus, Data_Out;
  logic [7:0] Data_In;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sam_mem_arbiter #(.AW(8), .DW(8), .MEM_DEPTH(64), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .pause(pause),
    .En(En), .Rw(Rw), .Address_Bus(Address_Bus), .Data_Out(Data_Out), .Data_In(Data_In),
    .err(err), .busy(busy)
  );

  // Memory model: command sampled on the edge where En=1, read data one cycle later
  logic [7:0] mem     [64];
  logic [7:0] ref_mem [64];

  always @(posedge clk) begin
    if (En) begin
      if (Rw) Data_In <= mem[Address_Bus[5:0]];
      else    mem[Address_Bus[5:0]] <= Data_Out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    if ($urandom_range(0, 7) == 0)      a = 8'($urandom_range(64, 255));
    else if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 7));
    else                                a = 8'($urandom_range(0, 63));
    return a;
  endfunction

  // One isolated transaction, started at a negedge while the arbiter is idle.
  // Returns at the negedge of the following idle cycle.
  task automatic do_txn(input string tag, input bit port, input bit rw,
                        input logic [7:0] a, input logic [7:0] wd, input logic [7:0] exp_rd);
    bit oor;
    int lat;
    int n;
    oor = (a >= 8'd64);
    lat = (rw && !oor) ? 2 + RD_LAT : 2;
    if (port) begin dbg_req = 1'b1; dbg_rw = rw; dbg_addr = a; dbg_wdata = wd; end
    else      begin cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd; end
    @(negedge clk);
    check({tag, "_en"},   32'(En), 32'(!oor));
    check({tag, "_rw"},   32'(Rw), 32'(oor ? 1'b1 : rw));
    if (!oor) check({tag, "_addr"}, 32'(Address_Bus), 32'(a));
    check({tag, "_dout"}, 32'(Data_Out), 32'((!oor && !rw) ? wd : 8'h00));
    n = 1;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (cpu_ack || dbg_ack) break;
      check({tag, "_en_wait"}, 32'(En), 32'(0));
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_ack"},     32'(port ? dbg_ack : cpu_ack), 32'(1));
    check({tag, "_oack"},    32'(port ? cpu_ack : dbg_ack), 32'(0));
    check({tag, "_rdata"},   32'(port ? dbg_rdata : cpu_rdata), 32'(exp_rd));
    check({tag, "_err"},     32'(err), 32'(oor));
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_clr"}, 32'(cpu_ack | dbg_ack), 32'(0));
  endtask

  // Transaction-level reference model state
  bit         act [2];
  bit         rq  [2];
  bit         rwv [2];
  logic [7:0] adv [2];
  logic [7:0] wdv [2];
  bit         have, own, trw, toor, mlast, e_en, e_ack, el0, el1, w;
  int         tg, ta, next_idle;
  logic [7:0] taddr, twd, trd;

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [7:0] v;
      v = (i == 8'h13) ? 8'h63 : 8'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    Data_In <= '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_en",    32'(En), 32'(0));
    check("rst_rw",    32'(Rw), 32'(1));
    check("rst_addr",  32'(Address_Bus), 32'(0));
    check("rst_dout",  32'(Data_Out), 32'(0));
    check("rst_acks",  32'({cpu_ack, dbg_ack}), 32'(0));
    check("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'(0));
    check("rst_err",   32'(err), 32'(0));
    check("rst_busy",  32'(busy), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Directed transactions
    do_txn("cpu_rd13", 1'b0, 1'b1, 8'h13, 8'h00, 8'h63);
    do_txn("dbg_wr04", 1'b1, 1'b0, 8'h04, 8'hA5, 8'h00);
    ref_mem[4] = 8'hA5;
    do_txn("cpu_rd04", 1'b0, 1'b1, 8'h04, 8'h00, 8'hA5);
    do_txn("cpu_rd40", 1'b0, 1'b1, 8'h40, 8'h00, 8'h00);

    // Reset while a read is waiting for data: dropped, no ack
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 8'h13;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'(1));
    rst = 1'b0;
    #1;
    check("mid_en",   32'(En), 32'(0));
    check("mid_rw",   32'(Rw), 32'(1));
    check("mid_busy", 32'(busy), 32'(0));
    check("mid_ack",  32'(cpu_ack), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("mid_noack", 32'(cpu_ack | dbg_ack), 32'(0));
    end

    // Randomized phase against the transaction-level model
    have = 1'b0; mlast = 1'b1; next_idle = 0;
    tg = -10; ta = -10; own = 1'b0; trw = 1'b1; toor = 1'b0;
    taddr = '0; twd = '0; trd = '0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rq[p] = 1'b0; rwv[p] = 1'b1; adv[p] = '0; wdv[p] = '0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      e_en  = have && (c == tg + 1) && !toor;
      e_ack = have && (c == ta);
      check("r_en",   32'(En), 32'(e_en));
      check("r_rw",   32'(Rw), 32'(e_en ? trw : 1'b1));
      if (e_en) check("r_addr", 32'(Address_Bus), 32'(taddr));
      check("r_dout", 32'(Data_Out), 32'((e_en && !trw) ? twd : 8'h00));
      check("r_busy", 32'(busy), 32'(have && c > tg));
      check("r_cpu_ack",   32'(cpu_ack), 32'(e_ack && !own));
      check("r_dbg_ack",   32'(dbg_ack), 32'(e_ack && own));
      check("r_cpu_rdata", 32'(cpu_rdata), 32'((e_ack && !own) ? trd : 8'h00));
      check("r_dbg_rdata", 32'(dbg_rdata), 32'((e_ack && own) ? trd : 8'h00));
      check("r_err",       32'(err), 32'(e_ack && toor));

      if (e_ack) begin
        act[own] = 1'b0;
        have = 1'b0;
      end

      if ($urandom_range(0, 7) == 0) pause = ~pause;
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 2) != 0) begin
          act[p] = 1'b1;
          rwv[p] = 1'($urandom);
          adv[p] = rand_addr();
          wdv[p] = 8'($urandom);
        end
        rq[p] = act[p];
      end
      // Fields and req of the granted port are irrelevant after the grant
      if (have && $urandom_range(0, 3) == 0) begin
        rq[own]  = 1'($urandom);
        rwv[own] = 1'($urandom);
        adv[own] = 8'($urandom);
        wdv[own] = 8'($urandom);
      end
      cpu_req = rq[0]; cpu_rw = rwv[0]; cpu_addr = adv[0]; cpu_wdata = wdv[0];
      dbg_req = rq[1]; dbg_rw = rwv[1]; dbg_addr = adv[1]; dbg_wdata = wdv[1];

      if (!have && c >= next_idle) begin
        el0 = rq[0] && !pause;
        el1 = rq[1];
        if (el0 || el1) begin
          w     = (el0 && el1) ? !mlast : el1;
          own   = w;
          trw   = rwv[w];
          taddr = adv[w];
          twd   = wdv[w];
          toor  = (taddr >= 8'd64);
          trd   = (trw && !toor) ? ref_mem[taddr[5:0]] : 8'h00;
          if (!trw && !toor) ref_mem[taddr[5:0]] = twd;
          tg        = c;
          ta        = c + ((trw && !toor) ? 2 + RD_LAT : 2);
          next_idle = ta + 1;
          mlast     = w;
          have      = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
